// File: rtl/nh_lcd_pkg.sv
// Shared definitions for the NH LCD stream writer: command bytes, FSM state
// codes, pixel format encoding and the beats-per-pixel helper.
package nh_lcd_pkg;

  localparam logic [7:0] CMD_START_MEM_WRITE = 8'h2C;
  localparam logic [7:0] CMD_CASET           = 8'h2A;
  localparam logic [7:0] CMD_PASET           = 8'h2B;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_TE   = 4'd1;
  localparam logic [3:0] ST_WIN_CMD   = 4'd2;
  localparam logic [3:0] ST_WIN_PARAM = 4'd3;
  localparam logic [3:0] ST_MEM_CMD   = 4'd4;
  localparam logic [3:0] ST_FETCH     = 4'd5;
  localparam logic [3:0] ST_BEAT      = 4'd6;
  localparam logic [3:0] ST_HOLD      = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  localparam logic FMT_RGB888 = 1'b0;
  localparam logic FMT_RGB565 = 1'b1;

  // Bus beats needed to move one pixel for a given bus width and format.
  function automatic logic [1:0] beats_per_pixel(input int bus_width, input logic fmt);
    if (fmt == FMT_RGB888)  return 2'd3;
    else if (bus_width == 16) return 2'd1;
    else                    return 2'd2;
  endfunction

endpackage

// File: rtl/nh_lcd_beat_mux.sv
// Maps a 24-bit pixel, beat index and format onto the LCD bus word.
module nh_lcd_beat_mux import nh_lcd_pkg::*; #(
  parameter int BUS_WIDTH = 8
) (
  input  logic [23:0]          pixel,
  input  logic [1:0]           beat,
  input  logic                 fmt,
  output logic [BUS_WIDTH-1:0] data
);

  logic [7:0]  comp;
  logic [15:0] w565;

  // RGB888 sends one colour component per beat, R first.
  always_comb begin
    case (beat)
      2'd0:    comp = pixel[23:16];
      2'd1:    comp = pixel[15:8];
      default: comp = pixel[7:0];
    endcase
  end

  assign w565 = {pixel[23:19], pixel[15:10], pixel[7:3]};

  generate
    if (BUS_WIDTH == 16) begin : g_w16
      assign data = (fmt == FMT_RGB565) ? w565 : {8'h00, comp};
    end else begin : g_w8
      assign data = (fmt == FMT_RGB565) ? ((beat == 2'd0) ? w565[15:8] : w565[7:0]) : comp;
    end
  endgenerate

endmodule

// File: rtl/nh_lcd_stream_writer.sv
// Pixel-stream to 8080-style LCD bus engine. Optional window setup
// (CASET/PASET before each frame) is compiled in with NH_LCD_WINDOW_EN.
module nh_lcd_stream_writer import nh_lcd_pkg::*; #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 32,
  parameter int WR_HOLD   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [CNT_WIDTH-1:0] i_num_pixels,
  input  logic                 i_enable_tearing,
  input  logic                 i_rgb565,
  input  logic                 i_tearing_effect,
  input  logic                 i_pixel_rdy,
  input  logic [23:0]          i_pixel_data,
  output logic                 o_pixel_stb,
  input  logic [15:0]          i_col_start,
  input  logic [15:0]          i_col_end,
  input  logic [15:0]          i_page_start,
  input  logic [15:0]          i_page_end,
  output logic                 o_cmd_mode,
  output logic [BUS_WIDTH-1:0] o_data_out,
  output logic                 o_write,
  output logic                 o_read,
  output logic                 o_data_out_en,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [15:0]          o_underflow_cnt
);

  localparam int HW = $clog2(WR_HOLD + 2);

  logic [3:0]           state, ret_state;
  logic [CNT_WIDTH-1:0] num_lat, pix_cnt;
  logic                 fmt_lat;
  logic [23:0]          shadow;
  logic [1:0]           beat, nbeats;
  logic [HW-1:0]        hold_cnt;
  logic                 te_q, stalled, frame_end;
  logic [23:0]          mux_pix;
  logic [1:0]           mux_beat;
  logic [BUS_WIDTH-1:0] mux_data;
  logic [3:0]           first_state;
  logic [7:0]           first_byte;

  assign o_read        = 1'b0;
  assign o_data_out_en = 1'b1;
  assign nbeats        = beats_per_pixel(BUS_WIDTH, fmt_lat);
  assign frame_end     = (pix_cnt == num_lat);
  assign o_pixel_stb   = (state == ST_FETCH) && !frame_end && i_enable && i_pixel_rdy;

  // In FETCH the first beat comes straight from the input; later beats replay the shadow.
  assign mux_pix  = (state == ST_FETCH) ? i_pixel_data : shadow;
  assign mux_beat = (state == ST_FETCH) ? 2'd0 : beat + 2'd1;

  nh_lcd_beat_mux #(.BUS_WIDTH(BUS_WIDTH)) u_mux (
    .pixel (mux_pix),
    .beat  (mux_beat),
    .fmt   (fmt_lat),
    .data  (mux_data)
  );

`ifdef NH_LCD_WINDOW_EN
  logic [3:0] win_idx;
  logic [7:0] win_next_byte;

  assign first_state = ST_WIN_CMD;
  assign first_byte  = CMD_CASET;

  // Byte following the one at win_idx in the CASET/PASET sequence.
  always_comb begin
    case (win_idx)
      4'd0:    win_next_byte = i_col_start[15:8];
      4'd1:    win_next_byte = i_col_start[7:0];
      4'd2:    win_next_byte = i_col_end[15:8];
      4'd3:    win_next_byte = i_col_end[7:0];
      4'd4:    win_next_byte = CMD_PASET;
      4'd5:    win_next_byte = i_page_start[15:8];
      4'd6:    win_next_byte = i_page_start[7:0];
      4'd7:    win_next_byte = i_page_end[15:8];
      4'd8:    win_next_byte = i_page_end[7:0];
      default: win_next_byte = 8'h00;
    endcase
  end
`else
  logic unused_win;
  assign unused_win  = ^{i_col_start, i_col_end, i_page_start, i_page_end};
  assign first_state = ST_MEM_CMD;
  assign first_byte  = CMD_START_MEM_WRITE;
`endif

  // Frame sequencer: command, optional window, then per-pixel beat/hold pairs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      ret_state       <= ST_IDLE;
      num_lat         <= '0;
      pix_cnt         <= '0;
      fmt_lat         <= FMT_RGB888;
      shadow          <= '0;
      beat            <= '0;
      hold_cnt        <= '0;
      te_q            <= 1'b0;
      stalled         <= 1'b0;
      o_write         <= 1'b0;
      o_cmd_mode      <= 1'b1;
      o_data_out      <= BUS_WIDTH'(CMD_START_MEM_WRITE);
      o_busy          <= 1'b0;
      o_frame_done    <= 1'b0;
      o_underflow_cnt <= '0;
`ifdef NH_LCD_WINDOW_EN
      win_idx         <= '0;
`endif
    end else begin
      o_frame_done <= 1'b0;
      te_q         <= i_tearing_effect;
      case (state)
        ST_IDLE: if (i_enable) begin
          num_lat <= i_num_pixels;
          fmt_lat <= i_rgb565;
          pix_cnt <= '0;
          stalled <= 1'b0;
          o_busy  <= 1'b1;
          if (i_enable_tearing) state <= ST_WAIT_TE;
          else begin
            state      <= first_state;
            o_write    <= 1'b1;
            o_cmd_mode <= 1'b0;
            o_data_out <= BUS_WIDTH'(first_byte);
`ifdef NH_LCD_WINDOW_EN
            win_idx    <= '0;
`endif
          end
        end
        ST_WAIT_TE: begin
          if (!i_enable) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (i_tearing_effect && !te_q) begin
            state      <= first_state;
            o_write    <= 1'b1;
            o_cmd_mode <= 1'b0;
            o_data_out <= BUS_WIDTH'(first_byte);
`ifdef NH_LCD_WINDOW_EN
            win_idx    <= '0;
`endif
          end
        end
        ST_WIN_CMD, ST_WIN_PARAM, ST_MEM_CMD, ST_BEAT: begin
          o_write   <= 1'b0;
          hold_cnt  <= HW'(WR_HOLD);
          ret_state <= state;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          else if (!i_enable) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            case (ret_state)
              ST_MEM_CMD: state <= ST_FETCH;
              ST_BEAT: begin
                if (beat == nbeats - 2'd1) begin
                  pix_cnt <= pix_cnt + CNT_WIDTH'(1);
                  state   <= ST_FETCH;
                end else begin
                  beat       <= beat + 2'd1;
                  state      <= ST_BEAT;
                  o_write    <= 1'b1;
                  o_data_out <= mux_data;
                end
              end
`ifdef NH_LCD_WINDOW_EN
              ST_WIN_CMD, ST_WIN_PARAM: begin
                o_write <= 1'b1;
                if (win_idx == 4'd9) begin
                  state      <= ST_MEM_CMD;
                  o_cmd_mode <= 1'b0;
                  o_data_out <= BUS_WIDTH'(CMD_START_MEM_WRITE);
                end else begin
                  win_idx    <= win_idx + 4'd1;
                  o_data_out <= BUS_WIDTH'(win_next_byte);
                  o_cmd_mode <= (win_idx != 4'd4);
                  state      <= (win_idx == 4'd4) ? ST_WIN_CMD : ST_WIN_PARAM;
                end
              end
`endif
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_FETCH: begin
          if (frame_end) state <= ST_DONE;
          else if (!i_enable) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (i_pixel_rdy) begin
            shadow     <= i_pixel_data;
            beat       <= 2'd0;
            stalled    <= 1'b0;
            state      <= ST_BEAT;
            o_write    <= 1'b1;
            o_cmd_mode <= 1'b1;
            o_data_out <= mux_data;
          end else if (!stalled) begin
            stalled <= 1'b1;
            if (o_underflow_cnt != 16'hFFFF) o_underflow_cnt <= o_underflow_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          o_frame_done <= 1'b1;
          o_busy       <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nh_lcd_stream_writer.sv
// Bench for nh_lcd_stream_writer: an 8-bit and a 16-bit instance share all
// inputs except i_enable; a queue-based reference model predicts the bus words.
module tb_nh_lcd_stream_writer;

`ifdef NH_LCD_WINDOW_EN
  localparam int WLEN = 10;
`else
  localparam int WLEN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en8 = 0, en16 = 0, ten = 0, r565 = 0, te = 0, rdy = 0;
  logic [31:0] npx = 0;
  logic [23:0] pdat = 0;
  logic [15:0] cs = 16'd0, ce = 16'd239, ps = 16'd0, pe = 16'd319;

  logic        stb8, cm8, wr8, rd8, den8, busy8, done8;
  logic [7:0]  d8;
  logic [15:0] uf8;
  logic        stb16, cm16, wr16, rd16, den16, busy16, done16;
  logic [15:0] d16, uf16;

  nh_lcd_stream_writer #(.BUS_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i_enable(en8), .i_num_pixels(npx), .i_enable_tearing(ten),
    .i_rgb565(r565), .i_tearing_effect(te), .i_pixel_rdy(rdy), .i_pixel_data(pdat),
    .o_pixel_stb(stb8), .i_col_start(cs), .i_col_end(ce), .i_page_start(ps), .i_page_end(pe),
    .o_cmd_mode(cm8), .o_data_out(d8), .o_write(wr8), .o_read(rd8), .o_data_out_en(den8),
    .o_busy(busy8), .o_frame_done(done8), .o_underflow_cnt(uf8));

  nh_lcd_stream_writer #(.BUS_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .i_enable(en16), .i_num_pixels(npx), .i_enable_tearing(ten),
    .i_rgb565(r565), .i_tearing_effect(te), .i_pixel_rdy(rdy), .i_pixel_data(pdat),
    .o_pixel_stb(stb16), .i_col_start(cs), .i_col_end(ce), .i_page_start(ps), .i_page_end(pe),
    .o_cmd_mode(cm16), .o_data_out(d16), .o_write(wr16), .o_read(rd16), .o_data_out_en(den16),
    .o_busy(busy16), .o_frame_done(done16), .o_underflow_cnt(uf16));

  logic [16:0] exp_q[$], log_q[$];
  logic [23:0] plan[$], pq[$];
  int          sq[$];
  int          nstb, ndone, stab_err, npass = 0, nfail = 0, ntotal = 0, act = 0;
  int          uf_exp[2];
  bit          take = 0;
  logic        pw8 = 0, pw16 = 0;
  logic [15:0] pd8 = 0, pd16 = 0;

  // Bus monitor: logs each write pulse and flags data moving while strobed or just after.
  always @(negedge clk) begin
    if (wr8 && !pw8)   log_q.push_back({cm8, 8'h00, d8});
    if (wr16 && !pw16) log_q.push_back({cm16, d16});
    if (pw8 && ({8'h00, d8} !== pd8)) stab_err++;
    if (pw16 && (d16 !== pd16))       stab_err++;
    if ((wr8 && pw8) || (wr16 && pw16)) stab_err++;
    if (stb8 || stb16)   nstb++;
    if (done8 || done16) ndone++;
    pw8 = wr8; pw16 = wr16; pd8 = {8'h00, d8}; pd16 = d16;
  end

  // Pixel source: presents the queue head, with an optional stall before a pixel.
  always @(negedge clk) begin
    if (take && pq.size() > 0) begin
      void'(pq.pop_front());
      void'(sq.pop_front());
    end
    if (pq.size() == 0) rdy = 1'b0;
    else if (sq[0] > 0) begin rdy = 1'b0; sq[0] = sq[0] - 1; end
    else begin rdy = 1'b1; pdat = pq[0]; end
    #1 take = stb8 | stb16;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input bit cm, input int v);
    exp_q.push_back({cm, v[15:0]});
  endtask

  // Reference model: expected bus words computed from the pixel plan.
  task automatic build_exp(input int bw, input bit f565);
    int r, g, b, v;
    exp_q.delete();
`ifdef NH_LCD_WINDOW_EN
    push_word(0, 'h2A); push_word(1, cs / 256); push_word(1, cs % 256);
    push_word(1, ce / 256); push_word(1, ce % 256);
    push_word(0, 'h2B); push_word(1, ps / 256); push_word(1, ps % 256);
    push_word(1, pe / 256); push_word(1, pe % 256);
`endif
    push_word(0, 'h2C);
    foreach (plan[i]) begin
      r = int'(plan[i]) / 65536; g = (int'(plan[i]) / 256) % 256; b = int'(plan[i]) % 256;
      v = (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
      if (f565 && bw == 16) push_word(1, v);
      else if (f565) begin push_word(1, v / 256); push_word(1, v % 256); end
      else begin push_word(1, r); push_word(1, g); push_word(1, b); end
    end
  endtask

  task automatic plan_rand(input int n);
    plan.delete();
    for (int i = 0; i < n; i++) plan.push_back(24'($urandom));
  endtask

  task automatic start_frame(input int s, input bit f565, input bit te_en,
                             input int stall_at, input int stall_len);
    @(negedge clk);
    act = s;
    pq = plan;
    sq.delete();
    foreach (plan[i]) sq.push_back((i == stall_at) ? stall_len : 0);
    build_exp((s != 0) ? 16 : 8, f565);
    log_q.delete(); nstb = 0; ndone = 0; stab_err = 0;
    npx = plan.size(); r565 = f565; ten = te_en;
    if (stall_at >= 0 && stall_at < plan.size()) uf_exp[s]++;
    if (s != 0) en16 = 1'b1; else en8 = 1'b1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (((act != 0) ? busy16 : busy8) && cyc < 4000) begin @(negedge clk); cyc++; end
  endtask

  task automatic finish_frame(input string tag);
    int cyc;
    wait_idle(cyc);
    en8 = 0; en16 = 0;
    repeat (2) @(negedge clk);
    chk({tag, "_timeout"}, cyc < 4000, 1);
    chk({tag, "_nwrites"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), log_q[i], exp_q[i]);
    chk({tag, "_stb"}, nstb, plan.size());
    chk({tag, "_done"}, ndone, 1);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_underflow"}, (act != 0) ? uf16 : uf8, uf_exp[act]);
  endtask

  initial begin
    int cyc, s, n, sa;
    bit f;
    uf_exp[0] = 0; uf_exp[1] = 0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr8", wr8, 0);     chk("rst_wr16", wr16, 0);
    chk("rst_d8", d8, 'h2C);    chk("rst_d16", d16, 'h2C);
    chk("rst_cm8", cm8, 1);     chk("rst_cm16", cm16, 1);
    chk("rst_busy", {busy8, busy16}, 0);
    chk("rst_done", {done8, done16}, 0);
    chk("rst_uf", {uf8, uf16}, 0);
    chk("rst_stb", {stb8, stb16}, 0);
    chk("rd_const", {rd8, rd16}, 0);
    chk("den_const", {den8, den16}, 2'b11);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    plan = '{24'h112233, 24'h445566};
    start_frame(0, 0, 0, -1, 0); finish_frame("d888");
    chk("d888_first_px", log_q[WLEN+1], {1'b1, 16'h0011});

    plan = '{24'hF8FCF8};
    start_frame(0, 1, 0, -1, 0); finish_frame("d565");
    chk("d565_byte1", log_q[WLEN+2], {1'b1, 16'h00FF});

    plan = '{24'h804020};
    start_frame(1, 1, 0, -1, 0); finish_frame("w565");
    chk("w565_word", log_q[WLEN+1], {1'b1, 16'h8204});

    plan_rand(3); start_frame(1, 0, 0, -1, 0); finish_frame("w888");

    plan_rand(3); start_frame(0, 0, 0, 1, 12); finish_frame("stall");
    chk("stall_cnt", uf8, 1);

    plan.delete(); start_frame(0, 0, 0, -1, 0); finish_frame("zero");

    for (int k = 0; k < 8; k++) begin
      s = int'($urandom_range(0, 1)); n = int'($urandom_range(0, 5)); f = 1'($urandom_range(0, 1));
      sa = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      plan_rand(n);
      start_frame(s, f, 0, sa, int'($urandom_range(12, 20)));
      finish_frame($sformatf("rnd%0d", k));
    end

    // Tearing: a TE level already high at entry must not start the frame.
    te = 1'b1;
    plan_rand(1); start_frame(0, 0, 1, -1, 0);
    repeat (8) @(negedge clk);
    chk("te_high_quiet", log_q.size(), 0);
    chk("te_busy", busy8, 1);
    te = 1'b0;
    repeat (3) @(negedge clk);
    chk("te_low_quiet", log_q.size(), 0);
    te = 1'b1;
    cyc = 0;
    while (log_q.size() == 0 && cyc < 10) begin @(negedge clk); cyc++; end
    chk("te_latency_ok", cyc <= 2, 1);
    finish_frame("te");
    te = 1'b0; ten = 1'b0;

    // Enable dropped during the second pixel's first beat.
    plan_rand(3); start_frame(0, 0, 0, -1, 0);
    cyc = 0;
    while (log_q.size() < WLEN + 5 && cyc < 500) begin @(negedge clk); cyc++; end
    en8 = 1'b0;
    wait_idle(cyc);
    repeat (3) @(negedge clk);
    chk("drop_timeout", cyc < 4000, 1);
    chk("drop_nwrites", log_q.size(), WLEN + 5);
    for (int i = 0; i < WLEN + 5 && i < log_q.size(); i++)
      chk($sformatf("drop_word%0d", i), log_q[i], exp_q[i]);
    chk("drop_done", ndone, 0);
    chk("drop_stb", nstb, 2);
    chk("drop_busy", busy8, 0);
    pq.delete(); sq.delete();
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a pixel beat.
    plan_rand(2); start_frame(0, 0, 0, -1, 0);
    cyc = 0;
    while (!(wr8 && log_q.size() >= WLEN + 2) && cyc < 500) begin @(negedge clk); cyc++; end
    chk("midrst_reached", cyc < 500, 1);
    rst = 1'b0;
    #1;
    chk("midrst_wr", wr8, 0);
    chk("midrst_data", d8, 'h2C);
    chk("midrst_cm", cm8, 1);
    chk("midrst_busy", busy8, 0);
    chk("midrst_stb", stb8, 0);
    en8 = 1'b0; pq.delete(); sq.delete();
    uf_exp[0] = 0; uf_exp[1] = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    plan_rand(2); start_frame(0, 1, 0, 0, 14); finish_frame("post_rst");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
